// File: rtl/regfile_uart_dump_if.sv
// regfile_uart_dump_if: register-file read port shared by the dump engine (master) and the register file (slave)
interface regfile_uart_dump_if #(
    parameter int ADDR_W = 5,
    parameter int N      = 16
);
    logic [ADDR_W-1:0] rd_addr;
    logic [N-1:0]      rd_data;
    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/regfile_uart_dump.sv
// regfile_uart_dump: walks every register through the read port and sends {addr, data MSB-first} as 8N1 UART bytes
module regfile_uart_dump #(
    parameter int N            = 16,
    parameter int ADDR_W       = 5,
    parameter int NREG         = 32,
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    regfile_uart_dump_if.master rf,
    output logic                tx_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int NB = 1 + N / 8;
    localparam int W  = 8 * NB;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [W-1:0]      buf_q, buf_d;
    logic [IW-1:0]     byte_q, byte_d;
    logic [2:0]        bit_q, bit_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic              tx_q, tx_d, busy_q, done_q;
    logic              tick;
    logic [7:0]        cur_d;

    assign tick = baud_q == BW'(CLKS_PER_BIT - 1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        baud_d  = (state_q inside {START, DATA, STOP} && !tick) ? baud_q + 1'b1 : '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                buf_d   = {8'(addr_q), rf.rd_data};
                byte_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_q != IW'(NB - 1)) begin
                        byte_d  = byte_q + 1'b1;
                        buf_d   = buf_q << 8;
                        state_d = START;
                    end else if (addr_q == ADDR_W'(NREG - 1)) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                addr_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is decoded from next-state values so the line itself comes straight from a flop
    assign cur_d = buf_d[W-1 -: 8];
    assign tx_d  = (state_d == START) ? 1'b0 : (state_d == DATA) ? cur_d[bit_d] : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            buf_q   <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DONE;
        end
    end

    assign rf.rd_addr = addr_q;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
endmodule

// File: tb/tb_regfile_uart_dump.sv
// tb_regfile_uart_dump: directed dump vectors plus hand sequences for framing, reset and back-to-back starts
module tb_regfile_uart_dump;
    localparam int N = 16, AW = 5, NREG = 4, CPB = 4;
    localparam int DUMP_CYC = NREG * (2 + 3 * 10 * CPB) + 1;

    typedef struct {
        logic reg_rd;
        logic mid_start;
        int   exp_cyc;
        int   exp_done;
        int   exp_bytes;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic tx, busy, done;
    logic reg_rd = 1'b0;
    logic [N-1:0] mem [NREG];
    logic [N-1:0] rd_q;
    int pass_cnt = 0, chk_cnt = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, edge_cnt = 0;
    logic [7:0] rx_q [$];
    int frame_err = 0, rx_cnt = 0;
    logic smp [10*CPB];
    logic [7:0] rx_byte;
    vec_t vecs [4];
    logic [7:0] exp_b [12];

    always #5 clk = ~clk;

    regfile_uart_dump_if #(.ADDR_W(AW), .N(N)) rf ();

    regfile_uart_dump #(.N(N), .ADDR_W(AW), .NREG(NREG), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .rf(rf),
        .tx_o(tx), .busy_o(busy), .done_o(done)
    );

    always @(posedge clk) rd_q <= mem[rf.rd_addr[1:0]];
    assign rf.rd_data = reg_rd ? rd_q : mem[rf.rd_addr[1:0]];

    always @(posedge tx or negedge tx) edge_cnt++;

    always @(posedge clk) begin
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // UART receiver: keeps every sample of a frame so bit widths can be checked exactly
    always @(negedge clk) begin
        if (!rst_n) rx_cnt = 0;
        else if (rx_cnt > 0 || tx === 1'b0) begin
            smp[rx_cnt] = tx;
            rx_cnt++;
            if (rx_cnt == 10 * CPB) begin
                for (int b = 0; b < 10; b++)
                    for (int c = 1; c < CPB; c++)
                        if (smp[b*CPB+c] !== smp[b*CPB]) frame_err++;
                if (smp[0] !== 1'b0 || smp[9*CPB] !== 1'b1) frame_err++;
                for (int b = 0; b < 8; b++) rx_byte[b] = smp[(b+1)*CPB];
                rx_q.push_back(rx_byte);
                rx_cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic load_mem(input logic [N-1:0] base);
        for (int i = 0; i < NREG; i++) mem[i] = base + N'(i);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_addr(input logic [AW-1:0] a);
        int i = 0;
        while (rf.rd_addr !== a && i < 1000) begin
            tick(1);
            i++;
        end
        chk("wait_rd_addr", 32'(rf.rd_addr), 32'(a));
    endtask

    task automatic wait_done(input int d0);
        int i = 0;
        while (done_cnt <= d0 && i < 2000) begin
            tick(1);
            i++;
        end
        chk("done_seen", 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic chk_bytes(input string tag, input int rx0);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s_byte%0d", tag, i),
                (rx0 + i < rx_q.size()) ? 32'(rx_q[rx0+i]) : 32'hdead, 32'(exp_b[i]));
    endtask

    initial begin
        int rx0, d0, sc, fe0, e0, lo, hi;
        vecs[0] = '{1'b0, 1'b0, DUMP_CYC, 1, 12};
        vecs[1] = '{1'b1, 1'b0, DUMP_CYC, 1, 12};
        vecs[2] = '{1'b0, 1'b1, DUMP_CYC, 1, 12};
        vecs[3] = '{1'b1, 1'b1, DUMP_CYC, 1, 12};
        exp_b = '{8'h00, 8'hA5, 8'hC0, 8'h01, 8'hA5, 8'hC1,
                  8'h02, 8'hA5, 8'hC2, 8'h03, 8'hA5, 8'hC3};
        load_mem(16'hA5C0);

        tick(2);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rd_addr", 32'(rf.rd_addr), 32'd0);
        rst_n = 1'b1;
        tick(1);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            reg_rd = vecs[v].reg_rd;
            load_mem(16'hA5C0);
            tick(2);
            rx0 = rx_q.size();
            d0  = done_cnt;
            fe0 = frame_err;
            sc  = cyc + 1;
            pulse_start();
            chk($sformatf("v%0d_busy_fetch", v), 32'(busy), 32'd1);
            chk($sformatf("v%0d_addr_fetch", v), 32'(rf.rd_addr), 32'd0);
            chk($sformatf("v%0d_tx_fetch", v), 32'(tx), 32'd1);
            tick(1);
            chk($sformatf("v%0d_tx_load", v), 32'(tx), 32'd1);
            tick(1);
            chk($sformatf("v%0d_tx_start", v), 32'(tx), 32'd0);
            if (vecs[v].mid_start) begin
                wait_addr(1);
                pulse_start();
            end
            wait_done(d0);
            chk($sformatf("v%0d_cycles", v), 32'(done_cyc - sc), 32'(vecs[v].exp_cyc));
            tick(5);
            chk($sformatf("v%0d_done_cnt", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_nbytes", v), 32'(rx_q.size() - rx0), 32'(vecs[v].exp_bytes));
            chk($sformatf("v%0d_frame_err", v), 32'(frame_err - fe0), 32'd0);
            chk_bytes($sformatf("v%0d", v), rx0);
        end

        // framing: 16'h8001 puts a lone 1 in bit 7 of byte 1 and bit 0 of byte 2
        do_reset();
        reg_rd = 1'b0;
        load_mem(16'hA5C0);
        mem[0] = 16'h8001;
        tick(2);
        rx0 = rx_q.size();
        d0  = done_cnt;
        fe0 = frame_err;
        pulse_start();
        lo = 0;
        while (tx !== 1'b0 && lo < 100) begin
            tick(1);
            lo++;
        end
        lo = 0;
        while (tx === 1'b0 && lo < 1000) begin
            tick(1);
            lo++;
        end
        chk("frame_low_run", 32'(lo), 32'(9 * CPB));
        hi = 0;
        while (tx === 1'b1 && hi < 1000) begin
            tick(1);
            hi++;
        end
        chk("frame_stop_run", 32'(hi), 32'(CPB));
        wait_done(d0);
        tick(5);
        chk("frame_byte1", (rx0 + 1 < rx_q.size()) ? 32'(rx_q[rx0+1]) : 32'hdead, 32'h80);
        chk("frame_byte2", (rx0 + 2 < rx_q.size()) ? 32'(rx_q[rx0+2]) : 32'hdead, 32'h01);
        chk("frame_err", 32'(frame_err - fe0), 32'd0);

        // asynchronous reset during DATA bit 2 of register 3's address byte (a 0 bit)
        do_reset();
        load_mem(16'hA5C0);
        pulse_start();
        wait_addr(3);
        tick(2 + 3 * CPB + 1);
        chk("prerst_tx", 32'(tx), 32'd0);
        chk("prerst_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rd_addr", 32'(rf.rd_addr), 32'd0);
        e0 = edge_cnt;
        d0 = done_cnt;
        tick(10);
        rst_n = 1'b1;
        tick(50);
        chk("postrst_tx_edges", 32'(edge_cnt - e0), 32'd0);
        chk("postrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);

        // back-to-back: start held high across DONE and the following IDLE cycle
        do_reset();
        load_mem(16'hA5C0);
        reg_rd = 1'b0;
        rx0 = rx_q.size();
        d0  = done_cnt;
        start = 1'b1;
        lo = 0;
        while (done !== 1'b1 && lo < 2000) begin
            tick(1);
            lo++;
        end
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_done_tx", 32'(tx), 32'd1);
        chk("b2b_done_busy", 32'(busy), 32'd1);
        tick(1);
        chk("b2b_idle_done", 32'(done), 32'd0);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_tx", 32'(tx), 32'd1);
        tick(1);
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        chk("b2b_restart_addr", 32'(rf.rd_addr), 32'd0);
        start = 1'b0;
        wait_done(d0 + 1);
        tick(5);
        chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
        chk("b2b_nbytes", 32'(rx_q.size() - rx0), 32'd24);
        chk_bytes("b2b_first", rx0);
        chk_bytes("b2b_second", rx0 + 12);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end
endmodule

// File: doc/regfile_uart_dump.md
# regfile_uart_dump

Read-side companion to the register-file write path: on a start request it walks every register address through a read port, captures each N-bit word and transmits it over an 8N1 UART line. It sits beside the register file in the top level, sharing a read-address/read-data port, and sends the complete register contents to a host terminal.

## Interface
- N, 16, register data width; must be a multiple of 8 (8 or 16 supported)
- ADDR_W, 5, register address width
- NREG, 32, number of registers dumped (addresses 0..NREG-1)
- CLKS_PER_BIT, 10416, clock cycles per UART bit (100 MHz / 9600 baud); minimum 2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  dump request, sampled high for one cycle in IDLE
- rd_addr  out  ADDR_W  register read address
- rd_data  in  N  register read data; combinational or one-cycle-registered read both tolerated
- tx  out  1  UART serial output, idle high
- busy  out  1  high from accepted start until DONE completes
- done  out  1  one-cycle pulse after last stop bit of last register

## Operation
- Reset (rst low, asynchronous): state IDLE, tx=1, busy=0, done=0, rd_addr=0, bit/byte/baud counters 0.
- Per register, NB = 1 + N/8 bytes sent: byte 0 = address zero-extended to 8 bits; then data bytes, most-significant byte first.
- Each byte: start bit (0), 8 data bits LSB first, stop bit (1); every bit held exactly CLKS_PER_BIT cycles.
- States:
  - IDLE: tx=1, busy=0; start=1 -> FETCH, rd_addr<=0.
  - FETCH: rd_addr stable; 1 cycle -> LOAD.
  - LOAD: capture {addr byte, rd_data} into shift buffer, byte index 0; 1 cycle -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx=current bit, 8 bits -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles; byte index < NB-1 -> index+1, START; else rd_addr == NREG-1 -> DONE; else rd_addr+1 -> FETCH.
  - DONE: done=1 one cycle, rd_addr<=0 -> IDLE.
- busy=1 in every state except IDLE.
- start while busy ignored (no queueing, no restart).
- rd_data sampled only in LOAD; changes at other times do not affect the frame in flight.
- rd_addr never exceeds NREG-1; no wrap to 0 except in DONE.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); partial byte abandoned; no done pulse.

## Timing
- start accepted at edge k: busy=1 and rd_addr=0 from k+1; tx falls at k+3 (FETCH, LOAD, then START).
- Per register: 2 + NB*10*CLKS_PER_BIT cycles (N=16: 2 + 30*CLKS_PER_BIT).
- Full dump: NREG*(2 + NB*10*CLKS_PER_BIT) cycles, plus 1 DONE cycle; busy falls the cycle after done.
- No idle gap between bytes of one register; 2-cycle gap (tx=1) between registers.
- start asserted in the same cycle as DONE: ignored; a new start is accepted from the following IDLE cycle.
- Outputs registered; tx glitch-free.

## Test plan
- Reset: rst=0 mid-DATA of register 3 -> tx=1, busy=0, done=0, rd_addr=0 immediately; no further edges on tx.
- Single dump, CLKS_PER_BIT=4, NREG=4, memory model reg[i]=16'hA5C0+i -> bytes received 00 A5 C0 01 A5 C1 02 A5 C2 03 A5 C3; done pulses once; 4*(2+120)+1 cycles from start to done.
- Bit framing: reg[0]=16'h8001 -> decoded bits of byte 2 = 1,0,0,0,0,0,0,0 LSB first; start bit low and stop bit high each exactly 4 cycles.
- Start while busy: pulse start during register 1 -> output stream identical to single-dump case; exactly one done.
- Registered read port: memory model with 1-cycle read latency -> same byte stream as combinational model.
- Back-to-back: start held high continuously -> second dump starts one cycle after first returns to IDLE; tx stays 1 during DONE/IDLE cycle; two done pulses.
